// File: rtl/cordic_arbiter.sv
// ---------------------------------------------------------------------------
// cordic_arbiter
//   Shares one cordic between N_CLIENTS requesters. Client (re, im) requests
//   are granted round-robin into a single-entry issue register that drives
//   the cordic input handshake. Every accepted request pushes the issuing
//   client's index into a tag FIFO; the FIFO head steers each returning
//   (amp, phi) result back to its owner, in issue order.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   cli_re_i/im_i     packed client operands, client k at [12k+11:12k]
//   cli_valid_i       per-client request valid
//   cli_ready_o       per-client request accepted (only the winner may be 1)
//   cli_amp_o/phi_o   result data, broadcast to all clients
//   cli_valid_o       result valid, one-hot to the owning client
//   cli_ready_i       per-client result ready
//   cor_re_o/im_o     issue register data to the cordic
//   cor_valid_o       issue register valid to the cordic
//   cor_ready_i       cordic input ready
//   cor_amp_i/phi_i   cordic result data
//   cor_valid_i       cordic result valid
//   cor_ready_o       result ready to the cordic (head owner's ready)
//   inflight_o        tag FIFO occupancy
//   err_o             sticky: a result arrived while no tag was outstanding
// ---------------------------------------------------------------------------
module cordic_arbiter #(
    parameter int N_CLIENTS    = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [12*N_CLIENTS-1:0]       cli_re_i,
    input  logic [12*N_CLIENTS-1:0]       cli_im_i,
    input  logic [N_CLIENTS-1:0]          cli_valid_i,
    output logic [N_CLIENTS-1:0]          cli_ready_o,
    output logic [11:0]                   cli_amp_o,
    output logic [10:0]                   cli_phi_o,
    output logic [N_CLIENTS-1:0]          cli_valid_o,
    input  logic [N_CLIENTS-1:0]          cli_ready_i,
    output logic [11:0]                   cor_re_o,
    output logic [11:0]                   cor_im_o,
    output logic                          cor_valid_o,
    input  logic                          cor_ready_i,
    input  logic [11:0]                   cor_amp_i,
    input  logic [10:0]                   cor_phi_i,
    input  logic                          cor_valid_i,
    output logic                          cor_ready_o,
    output logic [$clog2(MAX_INFLIGHT):0] inflight_o,
    output logic                          err_o
);

    localparam int TAG_W = $clog2(N_CLIENTS);
    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);
    localparam logic [TAG_W:0]   N_WIDE   = (TAG_W+1)'(N_CLIENTS);
    localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(N_CLIENTS - 1);

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] win;
    logic             win_found;
    logic [TAG_W:0]   cand;
    logic [11:0]      sel_re;
    logic [11:0]      sel_im;

    logic [TAG_W-1:0] tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] head;
    logic             fifo_empty;

    logic free;
    logic accept_en;
    logic accept;
    logic pop;

    // Occupancy is the registered count, so a full FIFO blocks a push even
    // when a pop happens in the same cycle. rst_i gates acceptance so no
    // client sees a grant while reset is held.
    assign free      = ~cor_valid_o | cor_ready_i;
    assign accept_en = ~rst_i & free & (count < MAX_CNT);
    assign accept    = win_found & accept_en;

    // Scan offsets from highest to lowest so the smallest offset from the
    // round-robin pointer is the last (winning) assignment.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = N_CLIENTS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (TAG_W+1)'(i);
            if (cand >= N_WIDE)
                cand = cand - N_WIDE;
            if (cli_valid_i[cand[TAG_W-1:0]]) begin
                win       = cand[TAG_W-1:0];
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_re = '0;
        sel_im = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if (win == TAG_W'(k)) begin
                sel_re = cli_re_i[12*k +: 12];
                sel_im = cli_im_i[12*k +: 12];
            end
        end
    end

    always_comb begin
        cli_ready_o      = '0;
        cli_ready_o[win] = accept;
    end

    // Return path: purely combinational steering by the FIFO head. With no
    // tag outstanding the cordic output is drained rather than stalled.
    assign head        = tag_mem[rd_ptr];
    assign fifo_empty  = (count == '0);
    assign cor_ready_o = fifo_empty | cli_ready_i[head];
    assign pop         = cor_valid_i & cor_ready_o & ~fifo_empty;
    assign cli_amp_o   = cor_amp_i;
    assign cli_phi_o   = cor_phi_i;
    assign inflight_o  = count;

    always_comb begin
        cli_valid_o = '0;
        if (!fifo_empty)
            cli_valid_o[head] = cor_valid_i;
    end

    always_ff @(posedge clk_i) begin
        if (accept)
            tag_mem[wr_ptr] <= win;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cor_valid_o <= 1'b0;
            cor_re_o    <= '0;
            cor_im_o    <= '0;
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err_o       <= 1'b0;
        end else begin
            // Issue register only changes when empty or being transferred,
            // so data stays stable while the cordic stalls.
            if (free) begin
                cor_valid_o <= accept;
                if (accept) begin
                    cor_re_o <= sel_re;
                    cor_im_o <= sel_im;
                end
            end
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (win == LAST_TAG) ? '0 : win + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (fifo_empty && cor_valid_i)
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;

    localparam int N    = 4;
    localparam int MAXI = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic signed [11:0] re_d [N];
    logic signed [11:0] im_d [N];
    logic [12*N-1:0] cli_re, cli_im;
    logic [N-1:0]    cli_valid, cli_ready_out, cli_valid_out, cli_rdy;
    logic [11:0]     cli_amp, cor_re, cor_im, cor_amp;
    logic [10:0]     cli_phi, cor_phi;
    logic            cor_valid, cor_ready, cor_valid_in, cor_ready_out, err;
    logic [$clog2(MAXI):0] inflight;

    always_comb begin
        cli_re = '0;
        cli_im = '0;
        for (int k = 0; k < N; k++) begin
            cli_re[12*k +: 12] = re_d[k];
            cli_im[12*k +: 12] = im_d[k];
        end
    end

    cordic_arbiter #(.N_CLIENTS(N), .MAX_INFLIGHT(MAXI)) dut (
        .clk_i(clk), .rst_i(rst),
        .cli_re_i(cli_re), .cli_im_i(cli_im), .cli_valid_i(cli_valid),
        .cli_ready_o(cli_ready_out), .cli_amp_o(cli_amp), .cli_phi_o(cli_phi),
        .cli_valid_o(cli_valid_out), .cli_ready_i(cli_rdy),
        .cor_re_o(cor_re), .cor_im_o(cor_im), .cor_valid_o(cor_valid),
        .cor_ready_i(cor_ready), .cor_amp_i(cor_amp), .cor_phi_i(cor_phi),
        .cor_valid_i(cor_valid_in), .cor_ready_o(cor_ready_out),
        .inflight_o(inflight), .err_o(err)
    );

    typedef struct {
        int                 k;
        logic signed [11:0] re;
        logic signed [11:0] im;
    } req_t;

    req_t exp_q[$];
    req_t cq[$];
    int   cq_rd = 0;
    int   grant_log[$];
    int   res_log[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    bit   stub_en = 1'b1;
    logic force_valid = 1'b0;

    function automatic logic [11:0] f_amp(input logic signed [11:0] re, input logic signed [11:0] im);
        real r, i;
        r = re;
        i = im;
        return 12'($rtoi($sqrt(r*r + i*i)));
    endfunction

    function automatic logic [10:0] f_phi(input logic signed [11:0] re, input logic signed [11:0] im);
        real r, i;
        r = re;
        i = im;
        return 11'($rtoi($atan2(i, r) * 1024.0 / 3.141592653589793));
    endfunction

    // Monitor / scoreboard: sampled mid-cycle, describes what the next edge does.
    always @(negedge clk) begin
        req_t e;
        if (rst) begin
            exp_q.delete();
            cq.delete();
            cq_rd = 0;
        end else begin
            if (cor_valid && cor_ready) begin
                e.k  = -1;
                e.re = $signed(cor_re);
                e.im = $signed(cor_im);
                cq.push_back(e);
            end
            for (int k = 0; k < N; k++) begin
                if (cli_valid[k] && cli_ready_out[k]) begin
                    e.k  = k;
                    e.re = re_d[k];
                    e.im = im_d[k];
                    exp_q.push_back(e);
                    grant_log.push_back(k);
                end
            end
            if (stub_en && cor_valid_in && cor_ready_out) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_spurious: result handshake with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    res_log.push_back(e.k);
                    if (cli_valid_out !== (N'(1) << e.k) || cli_amp !== f_amp(e.re, e.im) ||
                        cli_phi !== f_phi(e.re, e.im))
                        $display("FAIL sb_result: got valid=%b amp=%0d phi=%0d, expected valid=%b amp=%0d phi=%0d",
                                 cli_valid_out, cli_amp, cli_phi, N'(1) << e.k,
                                 f_amp(e.re, e.im), f_phi(e.re, e.im));
                    else
                        n_pass++;
                end
                cq_rd++;
            end
        end
    end

    // Cordic stub: one-cycle latency, results in order.
    always @(posedge clk) begin
        #1;
        if (stub_en) begin
            if (!rst && cq_rd < cq.size()) begin
                cor_valid_in = 1'b1;
                cor_amp      = f_amp(cq[cq_rd].re, cq[cq_rd].im);
                cor_phi      = f_phi(cq[cq_rd].re, cq[cq_rd].im);
            end else begin
                cor_valid_in = 1'b0;
            end
        end else begin
            cor_valid_in = force_valid;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cli_valid = '0;
        cli_rdy = '1;
        cor_ready = 1'b1;
        stub_en = 1'b1;
        force_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            re_d[k] = '0;
            im_d[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            sample();
            if (inflight == 0 && !cor_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        cli_valid = '1;
        cli_rdy = '1;
        cor_ready = 1'b1;
        cor_amp = '0;
        cor_phi = '0;
        cor_valid_in = 1'b0;
        for (int k = 0; k < N; k++) begin
            re_d[k] = 12'sd100;
            im_d[k] = 12'sd100;
        end
        #1 rst = 1'b1;
        #2;
        n_chk++; if (cor_valid !== 1'b0) $display("FAIL rst_cor_valid: got %b expected 0", cor_valid); else n_pass++;
        n_chk++; if (cor_re !== 12'd0 || cor_im !== 12'd0) $display("FAIL rst_cor_data: got %h/%h expected 0/0", cor_re, cor_im); else n_pass++;
        n_chk++; if (cli_ready_out !== '0) $display("FAIL rst_cli_ready: got %b expected 0000", cli_ready_out); else n_pass++;
        n_chk++; if (cli_valid_out !== '0) $display("FAIL rst_cli_valid: got %b expected 0000", cli_valid_out); else n_pass++;
        n_chk++; if (inflight !== '0) $display("FAIL rst_inflight: got %0d expected 0", inflight); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL rst_err: got %b expected 0", err); else n_pass++;
        cli_valid = '0;
        do_reset();
    endtask

    task automatic test_single;
        bit ok;
        do_reset();
        re_d[0] = 12'sd1000;
        im_d[0] = 12'sd500;
        cli_valid = 4'b0001;
        sample();
        n_chk++; if (cli_ready_out !== 4'b0001) $display("FAIL single_grant: got %b expected 0001", cli_ready_out); else n_pass++;
        tick();
        cli_valid = '0;
        sample();
        n_chk++;
        if (cor_valid !== 1'b1 || $signed(cor_re) !== 12'sd1000 || $signed(cor_im) !== 12'sd500)
            $display("FAIL single_issue: got v=%b re=%0d im=%0d expected v=1 re=1000 im=500", cor_valid, $signed(cor_re), $signed(cor_im));
        else n_pass++;
        n_chk++; if (inflight !== 3'd1) $display("FAIL single_inflight1: got %0d expected 1", inflight); else n_pass++;
        tick();
        sample();
        n_chk++;
        if (cli_valid_out !== 4'b0001 || cli_amp !== 12'd1118 || cli_phi !== 11'd151 || cor_valid !== 1'b0)
            $display("FAIL single_result: got v=%b amp=%0d phi=%0d cv=%b expected v=0001 amp=1118 phi=151 cv=0",
                     cli_valid_out, cli_amp, cli_phi, cor_valid);
        else n_pass++;
        tick();
        sample();
        n_chk++; if (inflight !== 3'd0) $display("FAIL single_inflight0: got %0d expected 0", inflight); else n_pass++;
        drain(ok);
        n_chk++; if (!ok) $display("FAIL single_drain: timeout, inflight=%0d", inflight); else n_pass++;
    endtask

    task automatic test_round_robin;
        bit ok;
        int g0, r0, cycles;
        do_reset();
        g0 = grant_log.size();
        r0 = res_log.size();
        cycles = 0;
        cli_valid = 4'b0111;
        while (grant_log.size() - g0 < 6 && cycles < 40) begin
            for (int k = 0; k < N; k++) begin
                re_d[k] = 12'(100 * (k + 1) + 7 * cycles);
                im_d[k] = 12'(40 * k - 3 * cycles);
            end
            sample();
            cycles++;
            tick();
        end
        cli_valid = '0;
        n_chk++; if (cycles != 6) $display("FAIL rr_throughput: got %0d cycles expected 6", cycles); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if (grant_log.size() - g0 <= i || grant_log[g0 + i] != i % 3)
                $display("FAIL rr_grant_%0d: got %0d expected %0d", i,
                         (grant_log.size() - g0 > i) ? grant_log[g0 + i] : -1, i % 3);
            else n_pass++;
        end
        drain(ok);
        n_chk++; if (!ok) $display("FAIL rr_drain: timeout, inflight=%0d", inflight); else n_pass++;
        n_chk++;
        if (res_log.size() - r0 != 6) $display("FAIL rr_result_count: got %0d expected 6", res_log.size() - r0);
        else begin
            ok = 1'b1;
            for (int i = 0; i < 6; i++) if (res_log[r0 + i] != i % 3) ok = 1'b0;
            if (!ok) $display("FAIL rr_result_order: owners not 0,1,2,0,1,2");
            else n_pass++;
        end
    endtask

    task automatic test_full_backpressure;
        bit ok;
        int g0, r0, cycles;
        do_reset();
        g0 = grant_log.size();
        r0 = res_log.size();
        cli_rdy = '0;
        cli_valid = 4'b1010;
        for (int c = 0; c < 10; c++) begin
            re_d[1] = 12'(500 + 10 * c);
            im_d[1] = -12'sd100;
            re_d[3] = 12'(-700 + c);
            im_d[3] = 12'sd300;
            sample();
            tick();
        end
        n_chk++; if (grant_log.size() - g0 != MAXI) $display("FAIL full_accepts: got %0d expected %0d", grant_log.size() - g0, MAXI); else n_pass++;
        sample();
        n_chk++; if (inflight !== 3'(MAXI)) $display("FAIL full_inflight: got %0d expected %0d", inflight, MAXI); else n_pass++;
        n_chk++; if (cli_ready_out !== '0) $display("FAIL full_blocked: got %b expected 0000", cli_ready_out); else n_pass++;
        n_chk++;
        if (cor_ready_out !== 1'b0 || cli_valid_out !== 4'b0010 || cor_valid_in !== 1'b1)
            $display("FAIL full_stall_out: got cr=%b cv=%b expected cr=0 cv=0010", cor_ready_out, cli_valid_out);
        else n_pass++;
        tick();
        cli_rdy = '1;
        cycles = 0;
        while (grant_log.size() - g0 < 8 && cycles < 40) begin
            re_d[1] = 12'(300 + cycles);
            re_d[3] = 12'(-200 - cycles);
            sample();
            cycles++;
            tick();
        end
        cli_valid = '0;
        n_chk++; if (grant_log.size() - g0 != 8) $display("FAIL full_resume: got %0d accepts expected 8", grant_log.size() - g0); else n_pass++;
        drain(ok);
        n_chk++; if (!ok) $display("FAIL full_drain: timeout, inflight=%0d", inflight); else n_pass++;
        n_chk++;
        if (res_log.size() - r0 != 8) $display("FAIL full_result_count: got %0d expected 8", res_log.size() - r0);
        else begin
            ok = 1'b1;
            for (int i = 0; i < 8; i++) if (res_log[r0 + i] != ((i % 2 == 0) ? 1 : 3)) ok = 1'b0;
            if (!ok) $display("FAIL full_result_order: owners not 1,3,1,3,...");
            else n_pass++;
        end
    endtask

    task automatic test_issue_stall;
        bit ok;
        int bad;
        do_reset();
        cor_ready = 1'b0;
        re_d[2] = 12'sd300;
        im_d[2] = -12'sd200;
        cli_valid = 4'b0100;
        sample();
        n_chk++; if (cli_ready_out !== 4'b0100) $display("FAIL stall_grant: got %b expected 0100", cli_ready_out); else n_pass++;
        tick();
        re_d[0] = 12'sd250;
        im_d[0] = 12'sd250;
        cli_valid = 4'b0001;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (cor_valid !== 1'b1 || $signed(cor_re) !== 12'sd300 || $signed(cor_im) !== -12'sd200 || cli_ready_out !== '0)
                bad++;
            tick();
            if (i == 4) cor_ready = 1'b1;
        end
        n_chk++; if (bad != 0) $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); else n_pass++;
        sample();
        n_chk++; if (cli_ready_out !== 4'b0001) $display("FAIL stall_release: got %b expected 0001", cli_ready_out); else n_pass++;
        tick();
        cli_valid = '0;
        sample();
        n_chk++;
        if (cor_valid !== 1'b1 || $signed(cor_re) !== 12'sd250)
            $display("FAIL stall_next: got v=%b re=%0d expected v=1 re=250", cor_valid, $signed(cor_re));
        else n_pass++;
        drain(ok);
        n_chk++; if (!ok) $display("FAIL stall_drain: timeout, inflight=%0d", inflight); else n_pass++;
    endtask

    task automatic test_err_sticky;
        int bad;
        do_reset();
        stub_en = 1'b0;
        cor_amp = 12'd77;
        cor_phi = 11'd5;
        @(negedge clk);
        force_valid = 1'b1;
        sample();
        n_chk++;
        if (cor_ready_out !== 1'b1 || cli_valid_out !== '0 || err !== 1'b0)
            $display("FAIL err_drain: got cr=%b cv=%b err=%b expected cr=1 cv=0000 err=0", cor_ready_out, cli_valid_out, err);
        else n_pass++;
        @(negedge clk);
        force_valid = 1'b0;
        #1;
        n_chk++; if (err !== 1'b1) $display("FAIL err_set: got %b expected 1", err); else n_pass++;
        bad = 0;
        repeat (5) begin
            sample();
            if (err !== 1'b1) bad++;
        end
        n_chk++; if (bad != 0) $display("FAIL err_sticky: got %0d cycles low expected 0", bad); else n_pass++;
        do_reset();
        sample();
        n_chk++; if (err !== 1'b0) $display("FAIL err_clear: got %b expected 0", err); else n_pass++;
    endtask

    task automatic test_reset_midflight;
        bit ok;
        int g0, cycles;
        do_reset();
        g0 = grant_log.size();
        cli_rdy = '0;
        re_d[0] = 12'sd400; im_d[0] = 12'sd100;
        re_d[1] = 12'sd200; im_d[1] = -12'sd300;
        cli_valid = 4'b0011;
        cycles = 0;
        while (grant_log.size() - g0 < 3 && cycles < 20) begin
            sample();
            cycles++;
            tick();
        end
        cli_valid = '0;
        sample();
        n_chk++; if (inflight !== 3'd3) $display("FAIL mid_pre_inflight: got %0d expected 3", inflight); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if (inflight !== '0 || cor_valid !== 1'b0 || cor_re !== '0 || cor_im !== '0 ||
            cli_ready_out !== '0 || cli_valid_out !== '0 || err !== 1'b0)
            $display("FAIL mid_async_clear: got infl=%0d cv=%b re=%h im=%h rdy=%b vo=%b err=%b expected all 0",
                     inflight, cor_valid, cor_re, cor_im, cli_ready_out, cli_valid_out, err);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cli_rdy = '1;
        cli_valid = 4'b0011;
        sample();
        n_chk++; if (cli_ready_out !== 4'b0001) $display("FAIL mid_rr_ptr: got %b expected 0001", cli_ready_out); else n_pass++;
        tick();
        cli_valid = '0;
        drain(ok);
        n_chk++; if (!ok || err !== 1'b0) $display("FAIL mid_drain: ok=%b err=%b expected ok=1 err=0", ok, err); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_backpressure();
        test_issue_stall();
        test_err_sticky();
        test_reset_midflight();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
